// File: rtl/dsi_pkg.sv
// Shared types and helpers for the DSI lane distributor.
//   DSI_NUM_LANES    : number of physical data lanes (fixed at 4)
//   DSI_LANE_ENTRY_W : width of one lane FIFO entry (LP flag + byte)
//   dist_state_t     : distributor FSM states
//   lane_entry_t     : one lane FIFO entry
//   strb_contiguous  : byte strobe is a run of ones starting at bit 0 (or empty)
//   strb_count       : number of bytes enabled by a contiguous strobe
package dsi_pkg;

  localparam int DSI_NUM_LANES    = 4;
  localparam int DSI_LANE_ENTRY_W = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HS,
    S_LP
  } dist_state_t;

  typedef struct packed {
    logic       lp;
    logic [7:0] data;
  } lane_entry_t;

  function automatic logic strb_contiguous(input logic [3:0] strb);
    return (strb == 4'b0000) || (strb == 4'b0001) || (strb == 4'b0011) ||
           (strb == 4'b0111) || (strb == 4'b1111);
  endfunction

  function automatic logic [2:0] strb_count(input logic [3:0] strb);
    logic [2:0] n;
    case (strb)
      4'b0001: n = 3'd1;
      4'b0011: n = 3'd2;
      4'b0111: n = 3'd3;
      4'b1111: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dsi_byte_rotator.sv
// Combinational byte-to-lane mapper.
//   buf_data_i     : 4-byte holding register contents
//   rd_i           : index of the next unsent byte in the buffer
//   cnt_i          : number of unsent bytes (0..4)
//   ptr_i          : lane that receives the next byte (0..n-1)
//   nlanes_i       : active lane count (1..4)
//   lane_byte_o    : byte presented to each lane
//   lane_target_o  : lanes that receive a byte this cycle
//   take_o         : number of bytes dispatched if the cycle is not stalled
module dsi_byte_rotator
  import dsi_pkg::*;
(
  input  logic [31:0]                         buf_data_i,
  input  logic [1:0]                          rd_i,
  input  logic [2:0]                          cnt_i,
  input  logic [1:0]                          ptr_i,
  input  logic [2:0]                          nlanes_i,
  output logic [DSI_NUM_LANES-1:0][7:0]       lane_byte_o,
  output logic [DSI_NUM_LANES-1:0]            lane_target_o,
  output logic [2:0]                          take_o
);

  // Byte j of the dispatch goes to lane (ptr + j) mod n. Because ptr < n and
  // j < n, a single conditional subtract replaces the modulo.
  always_comb begin
    logic [2:0] take;
    logic [2:0] sum;
    logic [1:0] lane;
    logic [1:0] src;
    take          = (cnt_i < nlanes_i) ? cnt_i : nlanes_i;
    lane_byte_o   = '0;
    lane_target_o = '0;
    sum           = '0;
    lane          = '0;
    src           = '0;
    for (int j = 0; j < DSI_NUM_LANES; j++) begin
      if (3'(j) < take) begin
        sum  = {1'b0, ptr_i} + 3'(j);
        lane = 2'((sum >= nlanes_i) ? (sum - nlanes_i) : sum);
        src  = rd_i + 2'(j);
        lane_target_o[lane] = 1'b1;
        lane_byte_o[lane]   = buf_data_i[{src, 3'b000} +: 8];
      end
    end
    take_o = take;
  end

endmodule

// File: rtl/dsi_lane_distributor.sv
// Byte scheduler between the packet assembler and the four lane FIFOs.
// Bytes of each 32-bit word are spread round-robin over the active lanes,
// every packet starting on lane 0; LP packets go to lane 0 only.
//   clk_phy / rst_n        : byte clock, asynchronous active-low reset
//   enable                 : allow new packets (checked at packet boundaries)
//   reg_lanes_number       : active lanes minus 1, sampled at packet start
//   in_valid/in_ready      : word handshake
//   in_data/in_strb        : bytes (byte0 first) and contiguous byte enables
//   in_last/in_lp          : end of packet, LP-mode packet
//   lane_fifo_wdata/write  : per-lane 9-bit entry {lp, byte} and write strobe
//   lane_fifo_full         : per-lane FIFO full
//   busy                   : packet in progress
//   err_strb               : pulse after a dropped non-contiguous-strobe word
module dsi_lane_distributor
  import dsi_pkg::*;
#(
  parameter int NUM_LANES = DSI_NUM_LANES
) (
  input  logic                              clk_phy,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [1:0]                        reg_lanes_number,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       in_data,
  input  logic [3:0]                        in_strb,
  input  logic                              in_last,
  input  logic                              in_lp,
  output logic [NUM_LANES*DSI_LANE_ENTRY_W-1:0] lane_fifo_wdata,
  output logic [NUM_LANES-1:0]              lane_fifo_write,
  input  logic [NUM_LANES-1:0]              lane_fifo_full,
  output logic                              busy,
  output logic                              err_strb
);

  dist_state_t                  state_q, state_d;
  logic [31:0]                  bufData_q, bufData_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [1:0]                   rd_q, rd_d;
  logic                         last_q, last_d;
  logic                         lp_q, lp_d;
  logic [1:0]                   ptr_q, ptr_d;
  logic [2:0]                   nLanes_q, nLanes_d;
  logic                         errStrb_q, errStrb_d;
  logic                         run_q;
  lane_entry_t [NUM_LANES-1:0]  hold_q, entry;

  logic [NUM_LANES-1:0][7:0]    laneByte;
  logic [NUM_LANES-1:0]         laneTarget;
  logic [NUM_LANES-1:0]         write;
  logic [2:0]                   take;
  logic [2:0]                   rotN;
  logic [1:0]                   rotPtr;
  logic                         inReady;

  // LP traffic behaves like a single-lane HS packet pinned to lane 0.
  assign rotN   = (state_q == S_LP) ? 3'd1 : nLanes_q;
  assign rotPtr = (state_q == S_LP) ? 2'd0 : ptr_q;

  dsi_byte_rotator u_rotator (
    .buf_data_i    (bufData_q),
    .rd_i          (rd_q),
    .cnt_i         (cnt_q),
    .ptr_i         (rotPtr),
    .nlanes_i      (rotN),
    .lane_byte_o   (laneByte),
    .lane_target_o (laneTarget),
    .take_o        (take)
  );

  // Dispatch is all-or-nothing: any full target lane stalls every lane.
  // A new word is only taken when this cycle drains a non-last buffer, so the
  // buffer never holds bytes of two words.
  always_comb begin
    logic       dispatch;
    logic       drains;
    logic [2:0] remain;
    logic [2:0] ptrSum;
    state_d   = state_q;
    bufData_d = bufData_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    last_d    = last_q;
    lp_d      = lp_q;
    ptr_d     = ptr_q;
    nLanes_d  = nLanes_q;
    errStrb_d = 1'b0;
    write     = '0;
    inReady   = 1'b0;
    dispatch  = (state_q != S_IDLE) && ((laneTarget & lane_fifo_full) == '0);
    remain    = cnt_q - take;
    drains    = dispatch && (remain == 3'd0);
    ptrSum    = {1'b0, ptr_q} + take;

    if (state_q == S_IDLE) begin
      inReady = enable && run_q;
    end else begin
      inReady = drains && !last_q;
      if (dispatch) begin
        write = laneTarget;
        cnt_d = remain;
        rd_d  = rd_q + take[1:0];
        if (state_q == S_HS)
          ptr_d = 2'((ptrSum >= nLanes_q) ? (ptrSum - nLanes_q) : ptrSum);
        if (drains && last_q) begin
          state_d = S_IDLE;
          ptr_d   = 2'd0;
        end
      end
    end

    if (in_valid && inReady) begin
      if (!strb_contiguous(in_strb)) begin
        errStrb_d = 1'b1;
      end else begin
        bufData_d = in_data;
        cnt_d     = strb_count(in_strb);
        rd_d      = 2'd0;
        last_d    = in_last;
        if (state_q == S_IDLE) begin
          nLanes_d = {1'b0, reg_lanes_number} + 3'd1;
          lp_d     = in_lp;
          state_d  = in_lp ? S_LP : S_HS;
        end
      end
    end
  end

  // Untargeted lanes keep presenting their previous entry.
  always_comb begin
    entry = hold_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (write[i]) begin
        entry[i].lp   = lp_q;
        entry[i].data = laneByte[i];
      end
    end
  end

  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bufData_q <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      last_q    <= 1'b0;
      lp_q      <= 1'b0;
      ptr_q     <= '0;
      nLanes_q  <= 3'd1;
      errStrb_q <= 1'b0;
      run_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      bufData_q <= bufData_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      last_q    <= last_d;
      lp_q      <= lp_d;
      ptr_q     <= ptr_d;
      nLanes_q  <= nLanes_d;
      errStrb_q <= errStrb_d;
      run_q     <= 1'b1;
      hold_q    <= entry;
    end
  end

  assign in_ready        = inReady;
  assign lane_fifo_write = write;
  assign lane_fifo_wdata = entry;
  assign busy            = (state_q != S_IDLE);
  assign err_strb        = errStrb_q;

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Directed testbench for dsi_lane_distributor. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_dsi_lane_distributor;

  logic        clk_phy = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  reg_lanes_number = 2'd3;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_strb = 4'hF;
  logic        in_last = 1'b0;
  logic        in_lp = 1'b0;
  logic [35:0] lane_fifo_wdata;
  logic [3:0]  lane_fifo_write;
  logic [3:0]  lane_fifo_full = '0;
  logic        busy;
  logic        err_strb;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk_phy = ~clk_phy;

  dsi_lane_distributor dut (
    .clk_phy          (clk_phy),
    .rst_n            (rst_n),
    .enable           (enable),
    .reg_lanes_number (reg_lanes_number),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_strb          (in_strb),
    .in_last          (in_last),
    .in_lp            (in_lp),
    .lane_fifo_wdata  (lane_fifo_wdata),
    .lane_fifo_write  (lane_fifo_write),
    .lane_fifo_full   (lane_fifo_full),
    .busy             (busy),
    .err_strb         (err_strb)
  );

  task automatic tick;
    @(negedge clk_phy);
  endtask

  task automatic test_reset;
    #1;
    checkCount++; if (in_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", in_ready); else passCount++;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL rst_write got %h want 0", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== 36'h0) $display("FAIL rst_wdata got %h want 0", lane_fifo_wdata); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passCount++;
    checkCount++; if (err_strb !== 1'b0) $display("FAIL rst_err got %0b want 0", err_strb); else passCount++;
    tick; rst_n = 1'b1;
    tick; enable = 1'b1; #1;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL rst_ready_after got %0b want 1", in_ready); else passCount++;
  endtask

  task automatic test_hs_four_lanes;
    tick; reg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'h33221100; in_strb = 4'hF; in_last = 1'b0; in_lp = 1'b0; #1;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL t1_ready_idle got %0b want 1", in_ready); else passCount++;
    tick; in_data = 32'h77665544; in_last = 1'b1; #1;
    checkCount++; if (lane_fifo_write !== 4'hF) $display("FAIL t1_write0 got %h want f", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h033, 9'h022, 9'h011, 9'h000}) $display("FAIL t1_wdata0 got %h", lane_fifo_wdata); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL t1_ready_b2b got %0b want 1", in_ready); else passCount++;
    tick; in_valid = 1'b0; in_last = 1'b0; #1;
    checkCount++; if (lane_fifo_write !== 4'hF) $display("FAIL t1_write1 got %h want f", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h077, 9'h066, 9'h055, 9'h044}) $display("FAIL t1_wdata1 got %h", lane_fifo_wdata); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("FAIL t1_ready_last got %0b want 0", in_ready); else passCount++;
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t1_busy_end got %0b want 0", busy); else passCount++;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL t1_write_end got %h want 0", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h077, 9'h066, 9'h055, 9'h044}) $display("FAIL t1_wdata_hold got %h", lane_fifo_wdata); else passCount++;
  endtask

  task automatic test_hs_three_lanes;
    tick; reg_lanes_number = 2'd2; in_valid = 1'b1; in_data = 32'h33221100; in_strb = 4'hF; in_last = 1'b0; #1;
    tick; in_data = 32'h00000044; in_strb = 4'h1; in_last = 1'b1; #1;
    checkCount++; if (lane_fifo_write !== 4'b0111) $display("FAIL t2_write0 got %h want 7", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h077, 9'h022, 9'h011, 9'h000}) $display("FAIL t2_wdata0 got %h", lane_fifo_wdata); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("FAIL t2_ready0 got %0b want 0", in_ready); else passCount++;
    tick; #1;
    checkCount++; if (lane_fifo_write !== 4'b0001) $display("FAIL t2_write1 got %h want 1", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata[8:0] !== 9'h033) $display("FAIL t2_lane0 got %h want 033", lane_fifo_wdata[8:0]); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL t2_ready1 got %0b want 1", in_ready); else passCount++;
    tick; in_valid = 1'b0; in_last = 1'b0; in_strb = 4'hF; #1;
    checkCount++; if (lane_fifo_write !== 4'b0010) $display("FAIL t2_write2 got %h want 2", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata[17:9] !== 9'h044) $display("FAIL t2_lane1 got %h want 044", lane_fifo_wdata[17:9]); else passCount++;
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t2_busy_end got %0b want 0", busy); else passCount++;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL t2_write_end got %h want 0", lane_fifo_write); else passCount++;
  endtask

  task automatic test_lp;
    logic [8:0] expLp [3];
    expLp[0] = 9'h1BB; expLp[1] = 9'h1CC; expLp[2] = 9'h1DD;
    tick; in_valid = 1'b1; in_data = 32'h00DDCCBB; in_strb = 4'b0111; in_last = 1'b1; in_lp = 1'b1; #1;
    tick; in_valid = 1'b0; in_last = 1'b0; in_lp = 1'b0; in_strb = 4'hF; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick; #1; end
      checkCount++; if (lane_fifo_write !== 4'b0001) $display("FAIL t3_write%0d got %h want 1", i, lane_fifo_write); else passCount++;
      checkCount++; if (lane_fifo_wdata[8:0] !== expLp[i]) $display("FAIL t3_lane0_%0d got %h want %h", i, lane_fifo_wdata[8:0], expLp[i]); else passCount++;
    end
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t3_busy_end got %0b want 0", busy); else passCount++;
  endtask

  task automatic test_stall;
    tick; reg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'h33221100; in_strb = 4'hF; in_last = 1'b0; #1;
    tick; in_data = 32'h77665544; lane_fifo_full = 4'b0100; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick; #1; end
      checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL t4_stall_write%0d got %h want 0", i, lane_fifo_write); else passCount++;
      checkCount++; if (in_ready !== 1'b0) $display("FAIL t4_stall_ready%0d got %0b want 0", i, in_ready); else passCount++;
    end
    tick; lane_fifo_full = 4'h0; #1;
    checkCount++; if (lane_fifo_write !== 4'hF) $display("FAIL t4_write0 got %h want f", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h033, 9'h022, 9'h011, 9'h000}) $display("FAIL t4_wdata0 got %h", lane_fifo_wdata); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL t4_ready0 got %0b want 1", in_ready); else passCount++;
    tick; in_data = 32'hBBAA9988; in_last = 1'b1; #1;
    checkCount++; if (lane_fifo_wdata !== {9'h077, 9'h066, 9'h055, 9'h044}) $display("FAIL t4_wdata1 got %h", lane_fifo_wdata); else passCount++;
    tick; in_valid = 1'b0; in_last = 1'b0; #1;
    checkCount++; if (lane_fifo_write !== 4'hF) $display("FAIL t4_write2 got %h want f", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h0BB, 9'h0AA, 9'h099, 9'h088}) $display("FAIL t4_wdata2 got %h", lane_fifo_wdata); else passCount++;
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t4_busy_end got %0b want 0", busy); else passCount++;
  endtask

  task automatic test_lane_change;
    tick; reg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'h33221100; in_strb = 4'hF; in_last = 1'b0; #1;
    tick; reg_lanes_number = 2'd1; in_data = 32'h77665544; in_last = 1'b1; #1;
    checkCount++; if (lane_fifo_write !== 4'hF) $display("FAIL t5_write0 got %h want f", lane_fifo_write); else passCount++;
    tick; in_valid = 1'b0; in_last = 1'b0; #1;
    checkCount++; if (lane_fifo_write !== 4'hF) $display("FAIL t5_write1 got %h want f", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h077, 9'h066, 9'h055, 9'h044}) $display("FAIL t5_wdata1 got %h", lane_fifo_wdata); else passCount++;
    tick; in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_strb = 4'hF; in_last = 1'b1; #1;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL t5_ready_idle got %0b want 1", in_ready); else passCount++;
    tick; in_valid = 1'b0; in_last = 1'b0; #1;
    checkCount++; if (lane_fifo_write !== 4'b0011) $display("FAIL t5_write2 got %h want 3", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata[17:0] !== {9'h0BB, 9'h0AA}) $display("FAIL t5_wdata2 got %h", lane_fifo_wdata[17:0]); else passCount++;
    tick; #1;
    checkCount++; if (lane_fifo_write !== 4'b0011) $display("FAIL t5_write3 got %h want 3", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata[17:0] !== {9'h0DD, 9'h0CC}) $display("FAIL t5_wdata3 got %h", lane_fifo_wdata[17:0]); else passCount++;
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t5_busy_end got %0b want 0", busy); else passCount++;
  endtask

  task automatic test_bad_strobes;
    tick; reg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'h12345678; in_strb = 4'b0101; in_last = 1'b0; #1;
    tick; in_valid = 1'b0; in_strb = 4'hF; #1;
    checkCount++; if (err_strb !== 1'b1) $display("FAIL err_pulse got %0b want 1", err_strb); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("FAIL err_busy got %0b want 0", busy); else passCount++;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL err_write got %h want 0", lane_fifo_write); else passCount++;
    tick; #1;
    checkCount++; if (err_strb !== 1'b0) $display("FAIL err_pulse_end got %0b want 0", err_strb); else passCount++;
    in_valid = 1'b1; in_strb = 4'h0; in_last = 1'b1;
    tick; in_valid = 1'b0; in_last = 1'b0; in_strb = 4'hF; #1;
    checkCount++; if (busy !== 1'b1) $display("FAIL zero_busy got %0b want 1", busy); else passCount++;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL zero_write got %h want 0", lane_fifo_write); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("FAIL zero_ready got %0b want 0", in_ready); else passCount++;
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL zero_idle got %0b want 0", busy); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL zero_ready_idle got %0b want 1", in_ready); else passCount++;
  endtask

  task automatic test_reset_mid_packet;
    tick; reg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'h0000BBAA; in_strb = 4'b0011; in_last = 1'b0; #1;
    tick; in_valid = 1'b0; in_strb = 4'hF; lane_fifo_full = 4'b0001; #1;
    checkCount++; if (busy !== 1'b1) $display("FAIL t6_busy_pre got %0b want 1", busy); else passCount++;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL t6_write_pre got %h want 0", lane_fifo_write); else passCount++;
    rst_n = 1'b0; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t6_busy_rst got %0b want 0", busy); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("FAIL t6_ready_rst got %0b want 0", in_ready); else passCount++;
    checkCount++; if (lane_fifo_wdata !== 36'h0) $display("FAIL t6_wdata_rst got %h want 0", lane_fifo_wdata); else passCount++;
    tick; #1;
    checkCount++; if (lane_fifo_write !== 4'h0) $display("FAIL t6_write_rst got %h want 0", lane_fifo_write); else passCount++;
    checkCount++; if (err_strb !== 1'b0) $display("FAIL t6_err_rst got %0b want 0", err_strb); else passCount++;
    tick; rst_n = 1'b1; lane_fifo_full = 4'h0;
    tick; in_valid = 1'b1; in_data = 32'h00332211; in_strb = 4'b0111; in_last = 1'b1; #1;
    checkCount++; if (in_ready !== 1'b1) $display("FAIL t6_ready_post got %0b want 1", in_ready); else passCount++;
    tick; in_valid = 1'b0; in_last = 1'b0; in_strb = 4'hF; #1;
    checkCount++; if (lane_fifo_write !== 4'b0111) $display("FAIL t6_write_post got %h want 7", lane_fifo_write); else passCount++;
    checkCount++; if (lane_fifo_wdata !== {9'h000, 9'h033, 9'h022, 9'h011}) $display("FAIL t6_wdata_post got %h", lane_fifo_wdata); else passCount++;
    tick; #1;
    checkCount++; if (busy !== 1'b0) $display("FAIL t6_busy_end got %0b want 0", busy); else passCount++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_hs_four_lanes;
    test_hs_three_lanes;
    test_lp;
    test_stall;
    test_lane_change;
    test_bad_strobes;
    test_reset_mid_packet;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
